regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port ARM register file, successor to the 15-entry 2R1W file.
//  Provides NUM_RD combinational read ports and 2 write ports (ALU result, load/base writeback),
//  and write-to-read bypass so writes move to the rising edge.
//  Storage is a resetless array, initialised by a hardware clear sweep after reset or on request.
//  The top address reads the externally supplied PC+8 (r15). Sits in the decode/writeback stages.
// PARAMETERS
//  DATA_W     32  register width in bits
//  ADDR_W     4   register address width; address 2**ADDR_W-1 is the PC slot
//  NUM_REGS   15  stored registers, 1..2**ADDR_W-1
//  NUM_RD     2   read ports, 1..4
//  CLEAR_VAL  0   value written to every entry by the clear sweep
// PORTS
//  clk    in   1               clock; all state updates on rising edge
//  reset  in   1               asynchronous, active-high reset
//  clr    in   1               soft clear request; sampled only in READY
//  ready  out  1               1 = file usable; 0 during clear sweep
//  we0    in   1               write enable, port 0 (priority port)
//  wa0    in   ADDR_W          write address, port 0
//  wd0    in   DATA_W          write data, port 0
//  we1    in   1               write enable, port 1
//  wa1    in   ADDR_W          write address, port 1
//  wd1    in   DATA_W          write data, port 1
//  ra     in   NUM_RD*ADDR_W   packed read addresses; port i = ra[i*ADDR_W +: ADDR_W]
//  r15    in   DATA_W          PC+8 value, returned for PC-slot reads
//  rd     out  NUM_RD*DATA_W   packed read data; port i = rd[i*DATA_W +: DATA_W]
//  par_err out NUM_RD          per-read-port parity error (see CONFIGURATION)
// BEHAVIOUR
//  FSM {CLEAR, READY}:
//  - reset asserted (any time, including mid-sweep): state=CLEAR, clr_idx=0, ready=0.
//  - CLEAR: each cycle writes CLEAR_VAL to RF[clr_idx] and increments clr_idx.
//    Leaves after entry NUM_REGS-1 is written; ready=1 on the following cycle.
//    Sweep length is exactly NUM_REGS cycles after reset deasserts.
//  - READY with clr=1: next cycle state=CLEAR, clr_idx=0, ready=0; clr ignored while in CLEAR.
//  Writes, READY only; ignored in CLEAR:
//  - port k writes RF[wak] <= wdk on the rising edge if wek=1.
//  - ignored if wak == 2**ADDR_W-1 (PC slot) or wak >= NUM_REGS.
//  - we0 & we1 & wa0==wa1: port 0 value is stored; port 1 is dropped.
//  Reads (combinational, zero latency), per port i with address a:
//  - a == 2**ADDR_W-1            -> r15
//  - a >= NUM_REGS (non-PC)      -> 0
//  - state CLEAR                 -> CLEAR_VAL
//  - we0 & wa0==a (valid addr)   -> wd0 (bypass)
//  - else we1 & wa1==a           -> wd1 (bypass)
//  - else                        -> RF[a]
//  - Precedence is top to bottom; results for one port never depend on other read ports.
//  Outputs after reset: ready=0, par_err=0; rd follows the read rules above (CLEAR_VAL / r15 / 0).
// CONFIGURATION
//  REGFILE_PARITY_EN defined:
//  - each entry stores an extra even-parity bit computed from the data written (sweep writes parity of CLEAR_VAL).
//  - par_err[i]=1 when port i reads a stored entry (not r15, not bypass, not CLEAR, not out-of-range)
//    whose data/parity mismatch; combinational.
//  REGFILE_PARITY_EN undefined:
//  - no parity storage; par_err tied to 0.
//  - port list is identical in both builds.
// TESTING
//  1. reset pulse, NUM_REGS=15 -> ready=0 for 15 cycles then 1; all addrs 0..14 read 0; ra=15 reads r15=0x0000_1008.
//  2. READY, we0=1 wa0=3 wd0=0xDEAD_BEEF, ra[0]=3 same cycle -> rd0=0xDEAD_BEEF (bypass); next cycle still 0xDEAD_BEEF from RF.
//  3. we0=1 wa0=5 wd0=0x11, we1=1 wa1=5 wd1=0x22 -> RF[5]=0x11; we1 wa1=15 wd1=0x33 -> ra=15 still reads r15.
//  4. reset asserted at sweep cycle 7 after prior writes -> sweep restarts at idx 0, ready rises 15 cycles after deassert, all reads 0.
//  5. READY, RF[2]=0x55; clr=1 one cycle -> ready=0 next cycle; writes during sweep dropped; after 15 cycles RF[2]=0.
//  6. REGFILE_PARITY_EN: force-flip one stored bit of RF[4] via hierarchical deposit, ra[1]=4 -> par_err=2'b10; without macro par_err=0.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port ARM register file: NUM_RD combinational read ports, two write ports with bypass,
// resetless storage cleared by a hardware sweep. Optional parity storage: REGFILE_PARITY_EN.
//
// state   | meaning
// S_CLEAR | sweep writes CLEAR_VAL to one entry per cycle; writes ignored, reads give CLEAR_VAL
// S_READY | normal operation; clr restarts the sweep
module regfile_mp #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 4,
  parameter int                NUM_REGS  = 15,
  parameter int                NUM_RD    = 2,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  output logic                     ready,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [DATA_W-1:0]        wd0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [DATA_W-1:0]        wd1,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  input  logic [DATA_W-1:0]        r15,
  output logic [NUM_RD*DATA_W-1:0] rd,
  output logic [NUM_RD-1:0]        par_err
);

  localparam logic [ADDR_W-1:0] PC_ADDR  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W:0]   NREGS    = (ADDR_W + 1)'(NUM_REGS);

  typedef enum logic {S_CLEAR = 1'b0, S_READY = 1'b1} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] clr_idx;
  logic              wr0_ok;
  logic              wr1_ok;

  logic [DATA_W-1:0] mem [NUM_REGS];

  function automatic logic in_file(input logic [ADDR_W-1:0] a);
    return (a != PC_ADDR) && ({1'b0, a} < NREGS);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_CLEAR;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_CLEAR: if (clr_idx == LAST_IDX) state_nxt = S_READY;
      S_READY: if (clr) state_nxt = S_CLEAR;
      default: state_nxt = S_CLEAR;
    endcase
  end

  always_comb begin
    ready = (state == S_READY);
  end

  // Index parks at 0 outside the sweep so a restart always begins at entry 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   clr_idx <= '0;
    else if (state == S_CLEAR)   clr_idx <= (clr_idx == LAST_IDX) ? '0 : clr_idx + ADDR_W'(1);
    else                         clr_idx <= '0;
  end

  assign wr0_ok = (state == S_READY) && we0 && in_file(wa0);
  assign wr1_ok = (state == S_READY) && we1 && in_file(wa1) && !(we0 && (wa0 == wa1));

  always_ff @(posedge clk) begin
    if (state == S_CLEAR) begin
      mem[clr_idx] <= CLEAR_VAL;
    end else begin
      if (wr0_ok) mem[wa0] <= wd0;
      if (wr1_ok) mem[wa1] <= wd1;
    end
  end

`ifdef REGFILE_PARITY_EN
  logic par_mem [NUM_REGS];

  always_ff @(posedge clk) begin
    if (state == S_CLEAR) begin
      par_mem[clr_idx] <= ^CLEAR_VAL;
    end else begin
      if (wr0_ok) par_mem[wa0] <= ^wd0;
      if (wr1_ok) par_mem[wa1] <= ^wd1;
    end
  end
`endif

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] q;

    assign a = ra[i*ADDR_W +: ADDR_W];

    always_comb begin
      q = '0;
      if (a == PC_ADDR)                q = r15;
      else if (!in_file(a))            q = '0;
      else if (state == S_CLEAR)       q = CLEAR_VAL;
      else if (we0 && (wa0 == a))      q = wd0;
      else if (we1 && (wa1 == a))      q = wd1;
      else                             q = mem[a];
    end

    assign rd[i*DATA_W +: DATA_W] = q;

`ifdef REGFILE_PARITY_EN
    // Only a genuine array read can carry a parity fault; every other source is clean by construction.
    logic hit_mem;
    assign hit_mem = in_file(a) && (state == S_READY) &&
                     !(we0 && (wa0 == a)) && !(we1 && (wa1 == a));
    assign par_err[i] = hit_mem && ((^mem[a]) != par_mem[a]);
`else
    assign par_err[i] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (default parameters, 2 read ports).
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        reset;
  logic        clr;
  logic        ready;
  logic        we0;
  logic [3:0]  wa0;
  logic [31:0] wd0;
  logic        we1;
  logic [3:0]  wa1;
  logic [31:0] wd1;
  logic [7:0]  ra;
  logic [31:0] r15;
  logic [63:0] rd;
  logic [1:0]  par_err;

  int n_chk  = 0;
  int n_fail = 0;

  regfile_mp dut (
    .clk(clk), .reset(reset), .clr(clr), .ready(ready),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra(ra), .r15(r15), .rd(rd), .par_err(par_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we0 = 1'b0;
    we1 = 1'b0;
    clr = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    r15   = 32'h0000_1008;
    ra    = {4'd15, 4'd3};
    tick();
    tick();
    @(negedge clk);
    n_chk++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", ready); end
    n_chk++; if (par_err !== 2'b00) begin n_fail++; $display("FAIL reset_par got %b want 00", par_err); end
    n_chk++; if (rd[31:0] !== 32'h0) begin n_fail++; $display("FAIL reset_rd_clear got %h want 0", rd[31:0]); end
    n_chk++; if (rd[63:32] !== 32'h0000_1008) begin n_fail++; $display("FAIL reset_rd_pc got %h want 00001008", rd[63:32]); end
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      n_chk++; if (ready !== 1'b0) begin n_fail++; $display("FAIL sweep_ready cyc %0d got %b want 0", i, ready); end
    end
    @(negedge clk);
    n_chk++; if (ready !== 1'b1) begin n_fail++; $display("FAIL sweep_done got %b want 1", ready); end
    for (int a = 0; a < 15; a++) begin
      ra = {4'(a), 4'(a)};
      #1;
      n_chk++; if (rd !== 64'h0) begin n_fail++; $display("FAIL swept_read addr %0d got %h want 0", a, rd); end
    end
    ra = {4'd15, 4'd15};
    #1;
    n_chk++; if (rd !== {32'h0000_1008, 32'h0000_1008}) begin n_fail++; $display("FAIL pc_read got %h want both 00001008", rd); end
  endtask

  task automatic test_bypass();
    tick();
    we0 = 1'b1; wa0 = 4'd3; wd0 = 32'hDEAD_BEEF;
    ra  = {4'd0, 4'd3};
    @(negedge clk);
    n_chk++; if (rd[31:0] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL bypass0 got %h want deadbeef", rd[31:0]); end
    n_chk++; if (rd[63:32] !== 32'h0) begin n_fail++; $display("FAIL bypass_other_port got %h want 0", rd[63:32]); end
    tick();
    idle();
    @(negedge clk);
    n_chk++; if (rd[31:0] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL stored0 got %h want deadbeef", rd[31:0]); end
    tick();
    we1 = 1'b1; wa1 = 4'd7; wd1 = 32'hCAFE_F00D;
    ra  = {4'd7, 4'd7};
    @(negedge clk);
    n_chk++; if (rd !== {32'hCAFE_F00D, 32'hCAFE_F00D}) begin n_fail++; $display("FAIL bypass1 got %h want cafef00d x2", rd); end
    tick();
    idle();
    @(negedge clk);
    n_chk++; if (rd[63:32] !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL stored1 got %h want cafef00d", rd[63:32]); end
  endtask

  task automatic test_dual_write();
    tick();
    we0 = 1'b1; wa0 = 4'd5; wd0 = 32'h11;
    we1 = 1'b1; wa1 = 4'd5; wd1 = 32'h22;
    ra  = {4'd5, 4'd5};
    @(negedge clk);
    n_chk++; if (rd[31:0] !== 32'h11) begin n_fail++; $display("FAIL collide_bypass got %h want 11", rd[31:0]); end
    tick();
    idle();
    @(negedge clk);
    n_chk++; if (rd[63:32] !== 32'h11) begin n_fail++; $display("FAIL collide_store got %h want 11", rd[63:32]); end
    tick();
    we1 = 1'b1; wa1 = 4'd15; wd1 = 32'h33;
    ra  = {4'd15, 4'd5};
    @(negedge clk);
    n_chk++; if (rd[63:32] !== 32'h0000_1008) begin n_fail++; $display("FAIL pc_write_bypass got %h want 00001008", rd[63:32]); end
    tick();
    idle();
    r15 = 32'h0000_2008;
    @(negedge clk);
    n_chk++; if (rd !== {32'h0000_2008, 32'h11}) begin n_fail++; $display("FAIL pc_after_write got %h want 00002008_00000011", rd); end
    tick();
    we0 = 1'b1; wa0 = 4'd8; wd0 = 32'h88;
    we1 = 1'b1; wa1 = 4'd9; wd1 = 32'h99;
    tick();
    idle();
    ra = {4'd9, 4'd8};
    @(negedge clk);
    n_chk++; if (rd !== {32'h99, 32'h88}) begin n_fail++; $display("FAIL dual_store got %h want 00000099_00000088", rd); end
  endtask

  task automatic test_reset_mid();
    for (int a = 0; a < 15; a++) begin
      tick();
      we0 = 1'b1; wa0 = 4'(a); wd0 = 32'h100 + 32'(a);
    end
    tick();
    idle();
    ra = {4'd14, 4'd10};
    @(negedge clk);
    n_chk++; if (rd !== {32'h10E, 32'h10A}) begin n_fail++; $display("FAIL fill got %h want 0000010e_0000010a", rd); end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    we0 = 1'b1; wa0 = 4'd12; wd0 = 32'h0BAD;
    ra  = {4'd12, 4'd10};
    repeat (7) tick();
    reset = 1'b1;
    @(negedge clk);
    n_chk++; if (rd !== 64'h0) begin n_fail++; $display("FAIL clear_read got %h want 0", rd); end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      n_chk++; if (ready !== 1'b0) begin n_fail++; $display("FAIL restart_ready cyc %0d got %b want 0", i, ready); end
    end
    @(negedge clk);
    n_chk++; if (ready !== 1'b1) begin n_fail++; $display("FAIL restart_done got %b want 1", ready); end
    idle();
    for (int a = 0; a < 15; a++) begin
      ra = {4'(a), 4'(a)};
      #1;
      n_chk++; if (rd !== 64'h0) begin n_fail++; $display("FAIL restart_read addr %0d got %h want 0", a, rd); end
    end
  endtask

  task automatic test_soft_clear();
    tick();
    we0 = 1'b1; wa0 = 4'd2; wd0 = 32'h55;
    tick();
    idle();
    ra = {4'd0, 4'd2};
    @(negedge clk);
    n_chk++; if (rd[31:0] !== 32'h55) begin n_fail++; $display("FAIL pre_clr got %h want 55", rd[31:0]); end
    tick();
    clr = 1'b1;
    @(negedge clk);
    n_chk++; if (ready !== 1'b1) begin n_fail++; $display("FAIL clr_same_cycle got %b want 1", ready); end
    tick();
    clr = 1'b0;
    we0 = 1'b1; wa0 = 4'd2; wd0 = 32'h77;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      n_chk++; if (ready !== 1'b0) begin n_fail++; $display("FAIL clr_ready cyc %0d got %b want 0", i, ready); end
      if (i == 3) begin
        n_chk++; if (rd[31:0] !== 32'h0) begin n_fail++; $display("FAIL clr_read got %h want 0", rd[31:0]); end
      end
      clr = (i == 5);
    end
    @(negedge clk);
    n_chk++; if (ready !== 1'b1) begin n_fail++; $display("FAIL clr_done got %b want 1", ready); end
    idle();
    #1;
    n_chk++; if (rd[31:0] !== 32'h0) begin n_fail++; $display("FAIL clr_result got %h want 0", rd[31:0]); end
  endtask

  task automatic test_parity();
    tick();
    we0 = 1'b1; wa0 = 4'd4; wd0 = 32'h0000_0F0F;
    tick();
    idle();
    ra = {4'd4, 4'd3};
    @(negedge clk);
    n_chk++; if (par_err !== 2'b00) begin n_fail++; $display("FAIL par_clean got %b want 00", par_err); end
    n_chk++; if (rd[63:32] !== 32'h0000_0F0F) begin n_fail++; $display("FAIL par_data got %h want 00000f0f", rd[63:32]); end
`ifdef REGFILE_PARITY_EN
    dut.par_mem[4] = ~dut.par_mem[4];
    #1;
    n_chk++; if (par_err !== 2'b10) begin n_fail++; $display("FAIL par_flip got %b want 10", par_err); end
    ra = {4'd4, 4'd4};
    #1;
    n_chk++; if (par_err !== 2'b11) begin n_fail++; $display("FAIL par_flip_both got %b want 11", par_err); end
    we1 = 1'b1; wa1 = 4'd4; wd1 = 32'h1;
    #1;
    n_chk++; if (par_err !== 2'b00) begin n_fail++; $display("FAIL par_bypass got %b want 00", par_err); end
    tick();
    idle();
    @(negedge clk);
    n_chk++; if (par_err !== 2'b00) begin n_fail++; $display("FAIL par_rewrite got %b want 00", par_err); end
`else
    ra = {4'd4, 4'd4};
    #1;
    n_chk++; if (par_err !== 2'b00) begin n_fail++; $display("FAIL par_tied got %b want 00", par_err); end
`endif
  endtask

  initial begin
    reset = 1'b1;
    clr = 1'b0; we0 = 1'b0; we1 = 1'b0;
    wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
    ra = '0; r15 = '0;
    test_reset();
    test_bypass();
    test_dual_write();
    test_reset_mid();
    test_soft_clear();
    test_parity();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
